dotprod_sequencer: RTL and testbench

//   Job controller for the 2-lane multiply-add pipeline (C = A1*B1 + A2*B2, 32-bit, no reset, no enable).

---
 rtl/dotprod_seq_pkg.sv | 27 ++
 rtl/dotprod_sequencer_if.sv | 46 ++++
 rtl/dotprod_vld_track.sv | 33 +++
 rtl/dotprod_sequencer.sv | 166 ++++++++++++++++
 tb/tb_dotprod_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dotprod_seq_pkg.sv
// Shared types for the dot-product job sequencer: FSM state encoding, datapath width
// and the operand-beat record handed to the multiply-add pipeline.
package dotprod_seq_pkg;

  localparam int DP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [DP_W-1:0] a1;
    logic [DP_W-1:0] a2;
    logic [DP_W-1:0] b1;
    logic [DP_W-1:0] b2;
  } beat_t;

  function automatic beat_t beat_zero();
    beat_t w_z;
    w_z = {(4*DP_W){1'b0}};
    return w_z;
  endfunction

endpackage

// File: rtl/dotprod_sequencer_if.sv
// Job, operand-stream, pipeline and result signals of the dot-product sequencer.
// Carries acc_ovf only when DOTPROD_SEQ_OVF_EN is defined.
interface dotprod_sequencer_if #(
  parameter int LEN_W = 16,
  parameter int ACC_W = 48
);
  import dotprod_seq_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [DP_W-1:0]  s_a1;
  logic [DP_W-1:0]  s_a2;
  logic [DP_W-1:0]  s_b1;
  logic [DP_W-1:0]  s_b2;
  logic [DP_W-1:0]  pipe_a1;
  logic [DP_W-1:0]  pipe_a2;
  logic [DP_W-1:0]  pipe_b1;
  logic [DP_W-1:0]  pipe_b2;
  logic [DP_W-1:0]  pipe_c;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
`ifdef DOTPROD_SEQ_OVF_EN
  logic             acc_ovf;
`endif

  modport master (
    output start, len, s_valid, s_a1, s_a2, s_b1, s_b2, pipe_c, res_ready,
    input  busy, s_ready, pipe_a1, pipe_a2, pipe_b1, pipe_b2, res_valid, res_data
`ifdef DOTPROD_SEQ_OVF_EN
    , input acc_ovf
`endif
  );

  modport slave (
    input  start, len, s_valid, s_a1, s_a2, s_b1, s_b2, pipe_c, res_ready,
    output busy, s_ready, pipe_a1, pipe_a2, pipe_b1, pipe_b2, res_valid, res_data
`ifdef DOTPROD_SEQ_OVF_EN
    , output acc_ovf
`endif
  );

endinterface

// File: rtl/dotprod_vld_track.sv
// Valid shift register mirroring the multiply-add pipeline depth; the tap marks
// cycles in which pipe_c carries a real lane sum.
module dotprod_vld_track #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vsr_in,
  output logic o_tap,
  output logic o_any_inflight
);

  logic [PIPE_LAT-1:0] r_vsr;
  logic [PIPE_LAT-1:0] w_vsr_nxt;

  // Next shift-register contents; any_inflight looks at the state after this edge.
  always_comb begin
    w_vsr_nxt = (r_vsr << 1'b1) | PIPE_LAT'(i_vsr_in);
  end

  // Shift register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsr <= {PIPE_LAT{1'b0}};
    end else begin
      r_vsr <= w_vsr_nxt;
    end
  end

  assign o_tap          = r_vsr[PIPE_LAT-1];
  assign o_any_inflight = |w_vsr_nxt;

endmodule

// File: rtl/dotprod_sequencer.sv
// Job controller for the 2-lane multiply-add pipeline: streams LEN beats, accumulates
// valid pipeline outputs and returns the sum. Optional feature macro: DOTPROD_SEQ_OVF_EN.
module dotprod_sequencer
  import dotprod_seq_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int LEN_W    = 16,
  parameter int ACC_W    = 48
) (
  input logic                clk,
  input logic                rst_n,
  dotprod_sequencer_if.slave io_bus
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [LEN_W-1:0] r_beats;
  logic             r_vsr_in;
  beat_t            r_pipe;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_start;
  logic             w_s_ready;
  logic             w_accept;
  logic             w_tap;
  logic             w_any_inflight;
  beat_t            w_beat;

  assign w_start   = (r_state == ST_IDLE) && io_bus.start;
  assign w_s_ready = (r_state == ST_RUN) && (r_beats != {LEN_W{1'b0}});
  assign w_accept  = io_bus.s_valid && w_s_ready;

  assign w_beat.a1 = io_bus.s_a1;
  assign w_beat.a2 = io_bus.s_a2;
  assign w_beat.b1 = io_bus.s_b1;
  assign w_beat.b2 = io_bus.s_b2;

  dotprod_vld_track #(
    .PIPE_LAT(PIPE_LAT)
  ) u_vld_track (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_vsr_in      (r_vsr_in),
    .o_tap         (w_tap),
    .o_any_inflight(w_any_inflight)
  );

  // Next-state logic of the job FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_nxt = (io_bus.len == {LEN_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && (r_beats == {{(LEN_W-1){1'b0}}, 1'b1})) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!w_any_inflight) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (io_bus.res_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Remaining-beat counter, loaded from len when a job starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats <= {LEN_W{1'b0}};
    end else if (w_start) begin
      r_beats <= io_bus.len;
    end else if (w_accept) begin
      r_beats <= r_beats - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      r_beats <= r_beats;
    end
  end

  // Operand stage: a bubble drives zeros so the pipeline never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe   <= beat_zero();
      r_vsr_in <= 1'b0;
    end else if (w_accept) begin
      r_pipe   <= w_beat;
      r_vsr_in <= 1'b1;
    end else begin
      r_pipe   <= beat_zero();
      r_vsr_in <= 1'b0;
    end
  end

`ifdef DOTPROD_SEQ_OVF_EN
  logic w_carry;
  logic r_ovf;

  assign {w_carry, w_acc_nxt} = {1'b0, r_acc} + {1'b0, ACC_W'(io_bus.pipe_c)};

  // Sticky carry-out flag for the current job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end else if (w_tap) begin
      r_ovf <= r_ovf | w_carry;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign io_bus.acc_ovf = r_ovf;
`else
  assign w_acc_nxt = r_acc + ACC_W'(io_bus.pipe_c);
`endif

  // Accumulator: pipe_c only contributes on cycles the valid tap marks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (w_start) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (w_tap) begin
      r_acc <= w_acc_nxt;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.s_ready   = w_s_ready;
  assign io_bus.res_valid = (r_state == ST_DONE);
  assign io_bus.res_data  = r_acc;
  assign io_bus.pipe_a1   = r_pipe.a1;
  assign io_bus.pipe_a2   = r_pipe.a2;
  assign io_bus.pipe_b1   = r_pipe.b1;
  assign io_bus.pipe_b2   = r_pipe.b2;

endmodule

// File: tb/tb_dotprod_sequencer.sv
// Self-checking bench for dotprod_sequencer: table-driven jobs, hand-written corner
// sequences and randomized jobs checked against a sum-of-products reference.
module tb_dotprod_sequencer;

  localparam int PIPE_LAT = 2;
  localparam int LEN_W    = 16;
`ifdef DOTPROD_SEQ_OVF_EN
  localparam int ACC_W    = 32;
`else
  localparam int ACC_W    = 48;
`endif

  typedef struct packed {
    int              n;
    int              gap;
    int              hold;
    logic [3:0][31:0] a1;
    logic [3:0][31:0] b1;
    logic [3:0][31:0] a2;
    logic [3:0][31:0] b2;
    logic [ACC_W-1:0] exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] r_p1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[5];
  logic [7:0][31:0] j_a1, j_b1, j_a2, j_b2;

  dotprod_sequencer_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus_if ();

  dotprod_sequencer #(
    .PIPE_LAT(PIPE_LAT),
    .LEN_W   (LEN_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural 2-stage multiply-add pipeline, no reset, lane sum wraps at 32 bits.
  always_ff @(posedge clk) begin
    r_p1          <= bus_if.pipe_a1 * bus_if.pipe_b1 + bus_if.pipe_a2 * bus_if.pipe_b2;
    bus_if.pipe_c <= r_p1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_beat(input int v, input int i, input logic [31:0] a1, input logic [31:0] b1,
                          input logic [31:0] a2, input logic [31:0] b2);
    tbl[v].a1[i] = a1;
    tbl[v].b1[i] = b1;
    tbl[v].a2[i] = a2;
    tbl[v].b2[i] = b2;
  endtask

  // Expected result from the plain arithmetic definition of the job.
  task automatic ref_job(input int n, output logic [ACC_W-1:0] res, output logic ovf);
    logic [63:0] total;
    logic [63:0] lane;
    total = 64'd0;
    for (int i = 0; i < n; i++) begin
      lane  = (64'(j_a1[i]) * 64'(j_b1[i]) + 64'(j_a2[i]) * 64'(j_b2[i])) % 64'h1_0000_0000;
      total = total + lane;
    end
    res = total[ACC_W-1:0];
    ovf = (total >= (64'd1 << ACC_W));
  endtask

  // Runs one job from a negedge and returns at a negedge with the sequencer idle.
  task automatic run_job(input string tag, input int n, input int gap, input int hold,
                         input logic [ACC_W-1:0] exp_res, input logic exp_ovf);
    int lat;
    int waitc;
    logic stable;
    logic [ACC_W-1:0] held;
    bus_if.start = 1'b1;
    bus_if.len   = LEN_W'(n);
    @(negedge clk);
    bus_if.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus_if.s_valid = 1'b0;
          @(negedge clk);
          chk({tag, "_bubble"}, 64'(bus_if.pipe_a1 | bus_if.pipe_a2 | bus_if.pipe_b1 | bus_if.pipe_b2), 64'd0);
        end
      end
      bus_if.s_valid = 1'b1;
      bus_if.s_a1 = j_a1[i];
      bus_if.s_b1 = j_b1[i];
      bus_if.s_a2 = j_a2[i];
      bus_if.s_b2 = j_b2[i];
      waitc = 0;
      while (!bus_if.s_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 20) chk({tag, "_ready_timeout"}, 64'(waitc), 64'd0);
      @(negedge clk);
      chk({tag, "_pipe_a1"}, 64'(bus_if.pipe_a1), 64'(j_a1[i]));
    end
    bus_if.s_valid = 1'b0;
    chk({tag, "_sready_after"}, 64'(bus_if.s_ready), 64'd0);
    lat = 1;
    while (!bus_if.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), (n == 0) ? 64'd1 : 64'(PIPE_LAT + 2));
    chk({tag, "_res_data"}, 64'(bus_if.res_data), 64'(exp_res));
`ifdef DOTPROD_SEQ_OVF_EN
    chk({tag, "_acc_ovf"}, 64'(bus_if.acc_ovf), 64'(exp_ovf));
`endif
    held   = bus_if.res_data;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        bus_if.start = 1'b1;
        bus_if.len   = LEN_W'(3);
      end
      @(negedge clk);
      bus_if.start = 1'b0;
      if (!bus_if.res_valid || bus_if.res_data !== held) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    chk({tag, "_idle_busy"}, 64'(bus_if.busy), 64'd0);
    chk({tag, "_idle_rvalid"}, 64'(bus_if.res_valid), 64'd0);
  endtask

  initial begin
    logic [ACC_W-1:0] e_res;
    logic e_ovf;
    int rn;
    bus_if.start = 1'b0;
    bus_if.len = '0;
    bus_if.s_valid = 1'b0;
    bus_if.s_a1 = '0;
    bus_if.s_a2 = '0;
    bus_if.s_b1 = '0;
    bus_if.s_b2 = '0;
    bus_if.res_ready = 1'b0;

    tbl[0] = '0; tbl[0].n = 1; tbl[0].exp_res = ACC_W'(39);
    set_beat(0, 0, 32'd3, 32'd5, 32'd4, 32'd6);
    tbl[1] = '0; tbl[1].n = 2; tbl[1].gap = 2; tbl[1].hold = 1; tbl[1].exp_res = ACC_W'(41);
    set_beat(1, 0, 32'd3, 32'd5, 32'd4, 32'd6);
    set_beat(1, 1, 32'd1, 32'd1, 32'd1, 32'd1);
    tbl[2] = '0; tbl[2].n = 0; tbl[2].hold = 2; tbl[2].exp_res = ACC_W'(0);
    tbl[3] = '0; tbl[3].n = 1; tbl[3].hold = 5; tbl[3].exp_res = ACC_W'(39);
    set_beat(3, 0, 32'd3, 32'd5, 32'd4, 32'd6);
    tbl[4] = '0; tbl[4].n = 3; tbl[4].gap = 1; tbl[4].exp_res = ACC_W'(50);
    set_beat(4, 0, 32'h8000_0000, 32'd2, 32'd0, 32'd0);
    set_beat(4, 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1);
    set_beat(4, 2, 32'd7, 32'd7, 32'd1, 32'd1);

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus_if.busy), 64'd0);
    chk("reset_sready", 64'(bus_if.s_ready), 64'd0);
    chk("reset_rvalid", 64'(bus_if.res_valid), 64'd0);
    chk("reset_rdata", 64'(bus_if.res_data), 64'd0);
    chk("reset_pipe", 64'(bus_if.pipe_a1 | bus_if.pipe_b2), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        j_a1[i] = tbl[v].a1[i];
        j_b1[i] = tbl[v].b1[i];
        j_a2[i] = tbl[v].a2[i];
        j_b2[i] = tbl[v].b2[i];
      end
      run_job($sformatf("vec%0d", v), tbl[v].n, tbl[v].gap, tbl[v].hold, tbl[v].exp_res, 1'b0);
    end

    // Reset in the middle of a 4-beat job, then a clean 1-beat job.
    bus_if.start = 1'b1;
    bus_if.len   = LEN_W'(4);
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.s_valid = 1'b1;
      bus_if.s_a1 = 32'd100 + 32'(i);
      bus_if.s_b1 = 32'd7;
      bus_if.s_a2 = 32'd9;
      bus_if.s_b2 = 32'd11;
      @(negedge clk);
    end
    bus_if.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus_if.busy), 64'd0);
    chk("midrst_rvalid", 64'(bus_if.res_valid), 64'd0);
    chk("midrst_rdata", 64'(bus_if.res_data), 64'd0);
    chk("midrst_pipe", 64'(bus_if.pipe_a1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_no_result", 64'(bus_if.res_valid), 64'd0);
    j_a1[0] = 32'd2; j_b1[0] = 32'd3; j_a2[0] = 32'd0; j_b2[0] = 32'd0;
    run_job("after_rst", 1, 0, 0, ACC_W'(6), 1'b0);

`ifdef DOTPROD_SEQ_OVF_EN
    for (int i = 0; i < 2; i++) begin
      j_a1[i] = 32'h0001_0000; j_b1[i] = 32'h0000_8000; j_a2[i] = 32'd0; j_b2[i] = 32'd0;
    end
    run_job("ovf_set", 2, 0, 0, ACC_W'(0), 1'b1);
    j_a1[0] = 32'd1; j_b1[0] = 32'd1; j_a2[0] = 32'd0; j_b2[0] = 32'd0;
    run_job("ovf_clr", 1, 0, 0, ACC_W'(1), 1'b0);
`endif

    for (int r = 0; r < 25; r++) begin
      rn = $urandom_range(1, 6);
      for (int i = 0; i < rn; i++) begin
        j_a1[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        j_b1[i] = $urandom();
        j_a2[i] = $urandom();
        j_b2[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      end
      ref_job(rn, e_res, e_ovf);
      run_job($sformatf("rnd%0d", r), rn, $urandom_range(0, 2), $urandom_range(0, 3), e_res, e_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
